// File: rtl/axis_uart_tx_cfg.sv
// Configurable AXI-Stream to UART serialiser: compile-time word length, parity and stop bits,
// one-entry holding register for gapless back-to-back frames, optional idle gap after last beats.
module axis_uart_tx_cfg #(
  parameter int unsigned clk_rate      = 100000000,
  parameter int unsigned Baud          = 115200,
  parameter int unsigned Word_len      = 8,
  parameter int unsigned Parity_mode   = 0,
  parameter int unsigned Stop_bits     = 1,
  parameter int unsigned Last_gap_bits = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [Word_len-1:0] tx_data,
  input  logic                tx_data_valid,
  input  logic                tx_data_last,
  output logic                tx_data_ready,
  output logic                Uart_tx,
  output logic                tx_busy
);

  localparam int unsigned BAUD_DIV = clk_rate / Baud;
  localparam int unsigned CW       = $clog2(BAUD_DIV) + 1;
  localparam int unsigned BW       = $clog2(Word_len + 1);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(Word_len - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(Stop_bits - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((Last_gap_bits == 0) ? 0 : Last_gap_bits - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_baud_cnt, w_baud_nxt;
  logic [BW-1:0]       r_bit_cnt, w_bit_nxt;
  logic [Word_len-1:0] r_shift, w_shift_nxt;
  logic [Word_len-1:0] r_hold_data;
  logic                r_hold_full, r_hold_last;
  logic                r_last, w_last_nxt;
  logic                r_par, w_par_nxt;
  logic                r_tx, w_tx_nxt;
  logic                w_tick, w_accept, w_load, w_frame_end, w_par_calc;

  assign w_tick        = (r_baud_cnt == BAUD_LAST);
  assign tx_data_ready = ~rst & ~r_hold_full;
  assign w_accept      = tx_data_valid & tx_data_ready;
  assign w_par_calc    = (^r_hold_data) ^ (Parity_mode == 1);
  assign Uart_tx       = r_tx;
  assign tx_busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_last_nxt  = r_last;
    w_par_nxt   = r_par;
    w_frame_end = 1'b0;
    w_load      = 1'b0;
    w_tx_nxt    = 1'b1;

    if (r_state != S_IDLE) w_baud_nxt = w_tick ? '0 : r_baud_cnt + 1'b1;

    case (r_state)
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == DATA_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = (Parity_mode != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == STOP_LAST) begin
            w_bit_nxt = '0;
            if (r_last && (Last_gap_bits != 0)) begin
              w_state_nxt = S_GAP;
            end else begin
              w_state_nxt = S_IDLE;
              w_frame_end = 1'b1;
            end
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_tick) begin
          if (r_bit_cnt == GAP_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_IDLE;
            w_frame_end = 1'b1;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A pending beat overrides the fall-back to IDLE so the next start bit follows with no gap.
    w_load = r_hold_full && ((r_state == S_IDLE) || w_frame_end);
    if (w_load) begin
      w_state_nxt = S_START;
      w_shift_nxt = r_hold_data;
      w_last_nxt  = r_hold_last;
      w_par_nxt   = w_par_calc;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
    end

    // The line is registered, so it follows the state being entered.
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_last      <= 1'b0;
      r_par       <= 1'b0;
      r_tx        <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_last     <= w_last_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      if (w_accept) begin
        r_hold_data <= tx_data;
        r_hold_last <= tx_data_last;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_cfg.sv
// Bench for axis_uart_tx_cfg: four configurations driven from shared data, line waveforms
// compared against frames built bit-by-bit from the framing rules.
module tb_axis_uart_tx_cfg;

  localparam int BDIV = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_last = 1'b0;
  logic [3:0] valid = '0;
  wire  [3:0] ready, line, busy;

  int errors = 0;
  int checks = 0;

  logic       cap_tx[$], cap_busy[$], cap_rdy[$], exp_tx[$];
  logic [7:0] bdat[$];
  logic       blast[$];
  int         busy_end;

  always #5 clk = ~clk;

  axis_uart_tx_cfg #(.clk_rate(16), .Baud(1), .Word_len(8), .Parity_mode(0), .Stop_bits(1),
                     .Last_gap_bits(2)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(valid[0]), .tx_data_last(tx_last),
    .tx_data_ready(ready[0]), .Uart_tx(line[0]), .tx_busy(busy[0]));

  axis_uart_tx_cfg #(.clk_rate(16), .Baud(1), .Word_len(8), .Parity_mode(2), .Stop_bits(1),
                     .Last_gap_bits(0)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(valid[1]), .tx_data_last(tx_last),
    .tx_data_ready(ready[1]), .Uart_tx(line[1]), .tx_busy(busy[1]));

  axis_uart_tx_cfg #(.clk_rate(16), .Baud(1), .Word_len(8), .Parity_mode(1), .Stop_bits(1),
                     .Last_gap_bits(0)) u_dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_data_valid(valid[2]), .tx_data_last(tx_last),
    .tx_data_ready(ready[2]), .Uart_tx(line[2]), .tx_busy(busy[2]));

  axis_uart_tx_cfg #(.clk_rate(16), .Baud(1), .Word_len(7), .Parity_mode(0), .Stop_bits(2),
                     .Last_gap_bits(1)) u_dut3 (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_data_valid(valid[3]), .tx_data_last(tx_last),
    .tx_data_ready(ready[3]), .Uart_tx(line[3]), .tx_busy(busy[3]));

  function automatic int cfg_wl(int d); return (d == 3) ? 7 : 8; endfunction
  function automatic int cfg_sb(int d); return (d == 3) ? 2 : 1; endfunction
  function automatic int cfg_pm(int d);
    case (d) 1: return 2; 2: return 1; default: return 0; endcase
  endfunction
  function automatic int cfg_lg(int d);
    case (d) 0: return 2; 3: return 1; default: return 0; endcase
  endfunction

  // Reference: list of bit levels for one frame, each stretched to BDIV cycles.
  task automatic model_frame(int d, logic [7:0] data, logic last);
    logic lv[$];
    int   ones = 0;
    lv.push_back(1'b0);
    for (int k = 0; k < cfg_wl(d); k++) begin
      lv.push_back(data[k]);
      ones += int'(data[k]);
    end
    if (cfg_pm(d) == 1) lv.push_back((ones % 2) == 0);
    else if (cfg_pm(d) == 2) lv.push_back((ones % 2) == 1);
    for (int k = 0; k < cfg_sb(d); k++) lv.push_back(1'b1);
    if (last) for (int k = 0; k < cfg_lg(d); k++) lv.push_back(1'b1);
    foreach (lv[j]) repeat (BDIV) exp_tx.push_back(lv[j]);
  endtask

  // Sample 0 is the cycle after the first accept (line still idle); beats follow back to back.
  task automatic build_exp(int d, int pad);
    exp_tx.delete();
    exp_tx.push_back(1'b1);
    foreach (bdat[j]) model_frame(d, bdat[j], blast[j]);
    busy_end = exp_tx.size() - 1;
    repeat (pad) exp_tx.push_back(1'b1);
  endtask

  task automatic drive_stream(int d, int ncap);
    int   i = 0;
    int   guard = 0;
    logic cap = 1'b0;
    logic acc;
    cap_tx.delete(); cap_busy.delete(); cap_rdy.delete();
    @(negedge clk);
    tx_data = bdat[0]; tx_last = blast[0]; valid[d] = 1'b1;
    while (cap_tx.size() < ncap && guard < 5000) begin
      acc = valid[d] && ready[d];
      @(negedge clk);
      guard++;
      if (acc) begin
        cap = 1'b1;
        i++;
        if (i < bdat.size()) begin
          tx_data = bdat[i]; tx_last = blast[i];
        end else begin
          valid[d] = 1'b0;
        end
      end
      if (cap) begin
        cap_tx.push_back(line[d]);
        cap_busy.push_back(busy[d]);
        cap_rdy.push_back(ready[d]);
      end
    end
    valid[d] = 1'b0;
  endtask

  function automatic int wave_mm(int n);
    int mm = 0;
    for (int j = 0; j < n; j++)
      if (j >= cap_tx.size() || j >= exp_tx.size() || cap_tx[j] !== exp_tx[j]) mm++;
    return mm;
  endfunction

  function automatic int busy_mm(int n);
    int mm = 0;
    for (int j = 0; j < n; j++)
      if (j >= cap_busy.size() || cap_busy[j] !== (j >= 1 && j <= busy_end)) mm++;
    return mm;
  endfunction

  function automatic int busy_count();
    int c = 0;
    foreach (cap_busy[j]) if (cap_busy[j] === 1'b1) c++;
    return c;
  endfunction

  function automatic int first_low_from(int s);
    for (int j = s; j < cap_tx.size(); j++) if (cap_tx[j] === 1'b0) return j;
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({line[d], busy[d], ready[d]} !== 3'b100) begin
        errors++;
        $display("FAIL reset_state dut%0d: tx/busy/ready=%b%b%b required 100", d, line[d], busy[d], ready[d]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 4'b1111) begin
      errors++;
      $display("FAIL reset_release_ready: ready=%b required 1111", ready);
    end
  endtask

  task automatic test_8n1();
    int n;
    bdat = '{8'h55}; blast = '{1'b0};
    build_exp(0, 40);
    n = exp_tx.size();
    drive_stream(0, n);
    checks++;
    if (cap_tx.size() != n) begin errors++; $display("FAIL 8n1_timeout: got %0d samples required %0d", cap_tx.size(), n); end
    checks++;
    if ({cap_tx[0], cap_tx[1]} !== 2'b10) begin errors++; $display("FAIL 8n1_fall_latency: samples0/1=%b%b required 10", cap_tx[0], cap_tx[1]); end
    checks++;
    if (wave_mm(n) != 0) begin errors++; $display("FAIL 8n1_wave: %0d mismatching cycles required 0", wave_mm(n)); end
    checks++;
    if (busy_count() != 160) begin errors++; $display("FAIL 8n1_busy_len: busy %0d cycles required 160", busy_count()); end
    checks++;
    if (busy_mm(n) != 0) begin errors++; $display("FAIL 8n1_busy_window: %0d mismatches required 0", busy_mm(n)); end
    checks++;
    if ({cap_rdy[0], cap_rdy[1]} !== 2'b01) begin errors++; $display("FAIL 8n1_ready: samples0/1=%b%b required 01", cap_rdy[0], cap_rdy[1]); end
  endtask

  task automatic test_parity();
    int n;
    for (int d = 1; d <= 2; d++) begin
      bdat = '{8'h07}; blast = '{1'b0};
      build_exp(d, 24);
      n = exp_tx.size();
      drive_stream(d, n);
      checks++;
      if (cap_tx[153] !== (d == 1)) begin errors++; $display("FAIL parity_bit dut%0d: got %b required %b", d, cap_tx[153], d == 1); end
      checks++;
      if (busy_count() != 176) begin errors++; $display("FAIL parity_len dut%0d: busy %0d required 176", d, busy_count()); end
      checks++;
      if (wave_mm(n) != 0) begin errors++; $display("FAIL parity_wave dut%0d: %0d mismatches required 0", d, wave_mm(n)); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bdat = '{8'hA5, 8'h3C}; blast = '{1'b0, 1'b0};
    build_exp(0, 20);
    n = exp_tx.size();
    drive_stream(0, n);
    checks++;
    if (wave_mm(n) != 0) begin errors++; $display("FAIL b2b_wave: %0d mismatches required 0", wave_mm(n)); end
    checks++;
    if (busy_mm(n) != 0) begin errors++; $display("FAIL b2b_busy: %0d mismatches required 0", busy_mm(n)); end
    checks++;
    if ({cap_rdy[2], cap_rdy[160], cap_rdy[161]} !== 3'b001) begin
      errors++;
      $display("FAIL b2b_ready: samples2/160/161=%b%b%b required 001", cap_rdy[2], cap_rdy[160], cap_rdy[161]);
    end
    checks++;
    if ({cap_tx[160], cap_tx[161]} !== 2'b10) begin errors++; $display("FAIL b2b_second_start: samples160/161=%b%b required 10", cap_tx[160], cap_tx[161]); end
  endtask

  task automatic test_gap();
    int n;
    for (int k = 0; k < 2; k++) begin
      bdat = '{8'h12, 8'h34}; blast = '{(k == 0), 1'b0};
      build_exp(0, 20);
      n = exp_tx.size();
      drive_stream(0, n);
      checks++;
      if (first_low_from(145) != ((k == 0) ? 193 : 161)) begin
        errors++;
        $display("FAIL gap_start last=%0d: second start at %0d required %0d", k == 0, first_low_from(145), (k == 0) ? 193 : 161);
      end
      checks++;
      if (wave_mm(n) != 0) begin errors++; $display("FAIL gap_wave last=%0d: %0d mismatches required 0", k == 0, wave_mm(n)); end
    end
  endtask

  task automatic test_word_stop();
    int n;
    int highs = 0;
    bdat = '{8'h7F}; blast = '{1'b0};
    build_exp(3, 20);
    n = exp_tx.size();
    drive_stream(3, n);
    for (int j = 129; j <= 160; j++) if (cap_tx[j] === 1'b1) highs++;
    checks++;
    if (highs != 32) begin errors++; $display("FAIL ws_stop_high: %0d high cycles required 32", highs); end
    checks++;
    if (busy_count() != 160) begin errors++; $display("FAIL ws_len: busy %0d required 160", busy_count()); end
    checks++;
    if (wave_mm(n) != 0) begin errors++; $display("FAIL ws_wave: %0d mismatches required 0", wave_mm(n)); end
  endtask

  task automatic test_random();
    int n, nb;
    for (int d = 0; d < 4; d++) begin
      for (int it = 0; it < 3; it++) begin
        bdat.delete(); blast.delete();
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          bdat.push_back(8'($urandom));
          blast.push_back(1'($urandom));
        end
        build_exp(d, 20);
        n = exp_tx.size();
        drive_stream(d, n);
        checks++;
        if (wave_mm(n) != 0) begin errors++; $display("FAIL rand_wave dut%0d it%0d: %0d mismatches required 0", d, it, wave_mm(n)); end
        checks++;
        if (busy_mm(n) != 0) begin errors++; $display("FAIL rand_busy dut%0d it%0d: %0d mismatches required 0", d, it, busy_mm(n)); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lows = 0;
    int busys = 0;
    bdat = '{8'hF0, 8'h81}; blast = '{1'b0, 1'b0};
    build_exp(0, 0);
    drive_stream(0, 70);
    checks++;
    if (wave_mm(70) != 0) begin errors++; $display("FAIL rstmid_pre_wave: %0d mismatches required 0", wave_mm(70)); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({line[0], busy[0], ready[0]} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_state: tx/busy/ready=%b%b%b required 100", line[0], busy[0], ready[0]);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_ready: ready=%b required 1", ready[0]); end
    repeat (400) begin
      @(negedge clk);
      if (line[0] !== 1'b1) lows++;
      if (busy[0] !== 1'b0) busys++;
    end
    checks++;
    if (lows != 0 || busys != 0) begin errors++; $display("FAIL rstmid_quiet: low cycles %0d busy cycles %0d required 0 0", lows, busys); end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_gap();
    test_word_stop();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
